// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: register address width,
// operand forwarding select and hazard FSM state encodings.
package hazard_unit_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int MC_CNT_W   = 8;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Operand source for the EX stage ALU inputs.
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,   // register file read value
      FWD_MEM = 2'b01,   // ALU result sitting in MEM (alu_y)
      FWD_WB  = 2'b10    // write-back data (regwd)
   } fwd_sel_t;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MC_BUSY = 1'b1
   } hz_state_t;

endpackage

// File: rtl/hazard_unit_fwd_compare.sv
// Per-operand comparator: picks the forwarding source for one ID source
// register and flags a load-use collision with the instruction in EX.
// x0 is hard-wired zero, so it never matches.
module fwd_compare
   import hazard_unit_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  use_rs,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_regwe,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_regwe,
   output fwd_sel_t              fwd_sel,
   output logic                  load_hit
);

   logic ex_match;
   logic mem_match;

   assign ex_match  = use_rs && ex_regwe  && (ex_rd  != '0) && (ex_rd  == rs);
   assign mem_match = use_rs && mem_regwe && (mem_rd != '0) && (mem_rd == rs);

   // A load in EX has no data yet, so it is a stall rather than a forward.
   assign load_hit = ex_match && ex_is_load;

   // Youngest producer wins: EX result beats the older MEM result.
   always_comb begin
      fwd_sel = FWD_REG;
      if (ex_match && !ex_is_load) begin
         fwd_sel = FWD_MEM;
      end else if (mem_match) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: multicycle EX stall with timeout abort, taken-branch
// flush, load-use stall and registered operand forwarding selects.
// Priority of events: multicycle stall > timeout abort > taken branch >
// load-use stall. All stall/flush outputs are combinational and held low
// while reset is asserted.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int MC_TIMEOUT = 64
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_regwe,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_regwe,
   input  logic                  b_taken,
   input  logic                  mc_start,
   input  logic                  mc_done,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  stall_ex,
   output logic                  flush_id,
   output logic                  flush_ex,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  mc_busy,
   output logic                  mc_error,
   output hz_state_t             dbg_state
);

   localparam logic [MC_CNT_W-1:0] TIMEOUT_LAST = MC_CNT_W'(MC_TIMEOUT - 1);

   hz_state_t             state;
   logic [MC_CNT_W-1:0]   mc_cnt;
   fwd_sel_t              fwd_a_q;
   fwd_sel_t              fwd_b_q;

   fwd_sel_t              sel_a;
   fwd_sel_t              sel_b;
   logic                  hit_a;
   logic                  hit_b;
   logic                  mc_stall;
   logic                  mc_abort;
   logic                  load_use;

   fwd_compare u_fwd_rs1 (
      .rs         (id_rs1),
      .use_rs     (id_use_rs1),
      .ex_rd      (ex_rd),
      .ex_regwe   (ex_regwe),
      .ex_is_load (ex_is_load),
      .mem_rd     (mem_rd),
      .mem_regwe  (mem_regwe),
      .fwd_sel    (sel_a),
      .load_hit   (hit_a)
   );

   fwd_compare u_fwd_rs2 (
      .rs         (id_rs2),
      .use_rs     (id_use_rs2),
      .ex_rd      (ex_rd),
      .ex_regwe   (ex_regwe),
      .ex_is_load (ex_is_load),
      .mem_rd     (mem_rd),
      .mem_regwe  (mem_regwe),
      .fwd_sel    (sel_b),
      .load_hit   (hit_b)
   );

   assign load_use = hit_a || hit_b;

   // The abort cycle itself is not stalled: EX is flushed instead.
   assign mc_abort = (state == ST_MC_BUSY) && !mc_done && (mc_cnt == TIMEOUT_LAST);
   assign mc_stall = ((state == ST_RUN)     && mc_start && !mc_done) ||
                     ((state == ST_MC_BUSY) && !mc_done && !mc_abort);

   // Stall/flush decode in priority order; everything low during reset.
   always_comb begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      if (!reset) begin
         if (mc_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
         end else if (mc_abort) begin
            flush_ex = 1'b1;
         end else if (b_taken) begin
            // Instructions behind a taken branch are wrong-path; any
            // load-use hazard they present is irrelevant.
            flush_id = 1'b1;
            flush_ex = 1'b1;
         end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
         end
      end
   end

   // Multicycle FSM, cycle counter and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_RUN;
         mc_cnt   <= '0;
         mc_error <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               mc_cnt <= '0;
               if (mc_start && !mc_done) begin
                  state <= ST_MC_BUSY;
               end
            end
            ST_MC_BUSY: begin
               if (mc_done) begin
                  state  <= ST_RUN;
                  mc_cnt <= '0;
               end else if (mc_cnt == TIMEOUT_LAST) begin
                  state    <= ST_RUN;
                  mc_cnt   <= '0;
                  mc_error <= 1'b1;
               end else begin
                  mc_cnt <= mc_cnt + MC_CNT_W'(1);
               end
            end
            default: begin
               state  <= ST_RUN;
               mc_cnt <= '0;
            end
         endcase
      end
   end

   // Forward selects follow the instruction moving into EX: cleared when a
   // bubble is loaded, frozen while EX is stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwd_a_q <= FWD_REG;
         fwd_b_q <= FWD_REG;
      end else if (flush_ex) begin
         fwd_a_q <= FWD_REG;
         fwd_b_q <= FWD_REG;
      end else if (!stall_ex) begin
         fwd_a_q <= sel_a;
         fwd_b_q <= sel_b;
      end
   end

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign mc_busy   = (state == ST_MC_BUSY);
   assign dbg_state = state;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (MC_TIMEOUT overridden to 8).
// Stimulus is applied 1 ns after each rising edge; each applied vector pushes
// its hand-computed response {stall_if,stall_id,stall_ex,flush_id,flush_ex,
// mc_busy,mc_error,fwd_a[1:0],fwd_b[1:0]} into a queue, and a monitor on the
// falling edge pops and compares.
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
   logic        id_use_rs1, id_use_rs2, ex_regwe, ex_is_load, mem_regwe;
   logic        b_taken, mc_start, mc_done;
   logic        stall_if, stall_id, stall_ex, flush_id, flush_ex;
   logic [1:0]  fwd_a, fwd_b;
   logic        mc_busy, mc_error;
   hz_state_t   dbg_state;

   logic [10:0] exp_q[$];
   string       name_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [10:0] act;
   logic [10:0] mon_e;
   string       mon_nm;

   // clock / reset
   always #5 clk = ~clk;

   hazard_unit #(.MC_TIMEOUT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rd      (ex_rd),
      .ex_regwe   (ex_regwe),
      .ex_is_load (ex_is_load),
      .mem_rd     (mem_rd),
      .mem_regwe  (mem_regwe),
      .b_taken    (b_taken),
      .mc_start   (mc_start),
      .mc_done    (mc_done),
      .stall_if   (stall_if),
      .stall_id   (stall_id),
      .stall_ex   (stall_ex),
      .flush_id   (flush_id),
      .flush_ex   (flush_ex),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .mc_busy    (mc_busy),
      .mc_error   (mc_error),
      .dbg_state  (dbg_state)
   );

   assign act = {stall_if, stall_id, stall_ex, flush_id, flush_ex,
                 mc_busy, mc_error, fwd_a, fwd_b};

   function automatic logic [10:0] ev(input bit si, input bit sd, input bit se,
                                      input bit fi, input bit fe, input bit bz,
                                      input bit er, input logic [1:0] fa,
                                      input logic [1:0] fb);
      return {si, sd, se, fi, fe, bz, er, fa, fb};
   endfunction

   // driver tasks
   task automatic drive(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input logic [4:0] exrd,
                        input bit exwe, input bit exld, input logic [4:0] memrd,
                        input bit memwe, input bit bt, input bit mcs, input bit mcd);
      @(posedge clk);
      #1;
      reset      = rst;
      id_rs1     = rs1;
      id_rs2     = rs2;
      id_use_rs1 = u1;
      id_use_rs2 = u2;
      ex_rd      = exrd;
      ex_regwe   = exwe;
      ex_is_load = exld;
      mem_rd     = memrd;
      mem_regwe  = memwe;
      b_taken    = bt;
      mc_start   = mcs;
      mc_done    = mcd;
   endtask

   task automatic zero(input bit rst);
      drive(rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mc(input bit rst, input bit done);
      drive(rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, done);
   endtask

   task automatic expect_v(input string nm, input logic [10:0] e);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e  = exp_q.pop_front();
         mon_nm = name_q.pop_front();
         n_vec++;
         if (act !== mon_e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (si sd se fi fe busy err fa fb)",
                     mon_nm, act, mon_e);
         end
      end
   end

   initial begin
      reset = 1'b1;
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = '0; ex_regwe = 1'b0; ex_is_load = 1'b0;
      mem_rd = '0; mem_regwe = 1'b0;
      b_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
      repeat (2) @(posedge clk);

      // reset: hazards presented during reset give no stall/flush
      drive(1, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 5'd0, 0, 1, 1, 0);
      expect_v("rst_comb", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      zero(0);
      expect_v("rst_release", ev(0,0,0,0,0,0,0,2'b00,2'b00));

      // load x5 in EX, ID reads x5
      drive(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0);
      expect_v("lu_stall", ev(1,1,0,0,1,0,0,2'b00,2'b00));
      drive(0, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 0);
      expect_v("lu_bubble", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      zero(0);
      expect_v("lu_fwd_wb", ev(0,0,0,0,0,0,0,2'b10,2'b00));

      // x7 in both EX and MEM, ID reads rs2=7
      drive(0, 5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0);
      expect_v("ex_mem_issue", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      zero(0);
      expect_v("fwd_b_ex_wins", ev(0,0,0,0,0,0,0,2'b00,2'b01));
      drive(0, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 0);
      expect_v("mem_issue", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      zero(0);
      expect_v("fwd_a_mem", ev(0,0,0,0,0,0,0,2'b10,2'b00));

      // x0 never hazards or forwards; unused source ignored
      drive(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
      expect_v("x0_no_stall", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      zero(0);
      expect_v("x0_no_fwd", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      drive(0, 5'd4, 5'd0, 0, 0, 5'd4, 1, 1, 5'd0, 0, 0, 0, 0);
      expect_v("unused_src", ev(0,0,0,0,0,0,0,2'b00,2'b00));

      // taken branch beats load-use; flush clears forward select
      drive(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 5'd0, 0, 1, 0, 0);
      expect_v("br_over_lu", ev(0,0,0,1,1,0,0,2'b00,2'b00));
      drive(0, 5'd6, 5'd0, 1, 0, 5'd6, 1, 0, 5'd0, 0, 1, 0, 0);
      expect_v("br_flush", ev(0,0,0,1,1,0,0,2'b00,2'b00));
      zero(0);
      expect_v("br_clears_fwd", ev(0,0,0,0,0,0,0,2'b00,2'b00));

      // multicycle op done on 6th cycle; forward select frozen while stalled
      drive(0, 5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 5'd0, 0, 0, 1, 0);
      expect_v("mc_enter", ev(1,1,1,0,0,0,0,2'b00,2'b00));
      drive(0, 5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 5'd0, 0, 0, 1, 0);
      expect_v("mc_busy1", ev(1,1,1,0,0,1,0,2'b00,2'b00));
      drive(0, 5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 5'd0, 0, 1, 1, 0);
      expect_v("mc_over_br", ev(1,1,1,0,0,1,0,2'b00,2'b00));
      for (int i = 0; i < 2; i++) begin
         drive(0, 5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 5'd0, 0, 0, 1, 0);
         expect_v("mc_busy_hold", ev(1,1,1,0,0,1,0,2'b00,2'b00));
      end
      drive(0, 5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 5'd0, 0, 0, 1, 1);
      expect_v("mc_done_release", ev(0,0,0,0,0,1,0,2'b00,2'b00));
      zero(0);
      expect_v("mc_back_run", ev(0,0,0,0,0,0,0,2'b01,2'b00));

      // start and done together in RUN: no stall, no busy
      mc(0, 1);
      expect_v("mc_same_cycle", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      zero(0);
      expect_v("mc_no_busy", ev(0,0,0,0,0,0,0,2'b00,2'b00));

      // timeout abort with MC_TIMEOUT = 8
      mc(0, 0);
      expect_v("to_enter", ev(1,1,1,0,0,0,0,2'b00,2'b00));
      for (int i = 0; i < 7; i++) begin
         mc(0, 0);
         expect_v("to_wait", ev(1,1,1,0,0,1,0,2'b00,2'b00));
      end
      mc(0, 0);
      expect_v("to_abort", ev(0,0,0,0,1,1,0,2'b00,2'b00));
      zero(0);
      expect_v("to_error", ev(0,0,0,0,0,0,1,2'b00,2'b00));
      drive(0, 5'd2, 5'd0, 1, 0, 5'd2, 1, 1, 5'd0, 0, 0, 0, 0);
      expect_v("err_no_block", ev(1,1,0,0,1,0,1,2'b00,2'b00));

      // reset three cycles into MC_BUSY
      mc(0, 0);
      expect_v("rst_mc_enter", ev(1,1,1,0,0,0,1,2'b00,2'b00));
      for (int i = 0; i < 3; i++) begin
         mc(0, 0);
         expect_v("rst_mc_busy", ev(1,1,1,0,0,1,1,2'b00,2'b00));
      end
      mc(1, 0);
      expect_v("rst_mid_mc", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      zero(0);
      expect_v("rst_mid_release", ev(0,0,0,0,0,0,0,2'b00,2'b00));
      mc(0, 0);
      expect_v("post_rst_run", ev(1,1,1,0,0,0,0,2'b00,2'b00));
      mc(0, 1);
      expect_v("post_rst_done", ev(0,0,0,0,0,1,0,2'b00,2'b00));
      zero(0);
      expect_v("post_rst_idle", ev(0,0,0,0,0,0,0,2'b00,2'b00));

      // final report
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
